// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES ripple chunks, one result per clock.
// Optional two's-complement overflow output is enabled by defining PIPE_ADD_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int CW    = CHUNK + 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             stall_s;
  logic [WIDTH-1:0] bb_s;
  logic             c0_s;

  assign bb_s     = sub ? ~b : b;
  assign c0_s     = sub ? ~cin : cin;
  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;

  // Stage g consumes the lowest remaining chunk of the skewed operands and
  // appends its result chunk to the deskewed partial sum from stage g-1.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int REM = WIDTH - g * CHUNK;
    localparam int LOW = g * CHUNK;

    logic [REM-1:0]       a_src_s;
    logic [REM-1:0]       bb_src_s;
    logic                 c_src_s;
    logic                 v_src_s;
    logic [CHUNK:0]       part_s;
    logic [LOW+CHUNK-1:0] sum_nxt_s;

    logic                 v_r;
    logic                 c_r;
    logic [LOW+CHUNK-1:0] sum_r;

    if (g == 0) begin : g_first
      assign a_src_s   = a;
      assign bb_src_s  = bb_s;
      assign c_src_s   = c0_s;
      assign v_src_s   = in_valid;
      assign sum_nxt_s = part_s[CHUNK-1:0];
    end else begin : g_next
      assign a_src_s   = g_stage[g-1].g_skew.a_r;
      assign bb_src_s  = g_stage[g-1].g_skew.bb_r;
      assign c_src_s   = g_stage[g-1].c_r;
      assign v_src_s   = g_stage[g-1].v_r;
      assign sum_nxt_s = {part_s[CHUNK-1:0], g_stage[g-1].sum_r};
    end

    assign part_s = {1'b0, a_src_s[CHUNK-1:0]} + {1'b0, bb_src_s[CHUNK-1:0]} + CW'(c_src_s);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (!stall_s) begin
        v_r   <= v_src_s;
        c_r   <= part_s[CHUNK];
        sum_r <= sum_nxt_s;
      end
    end

    if (g < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_r;
      logic [REM-CHUNK-1:0] bb_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_r  <= '0;
          bb_r <= '0;
        end else if (!stall_s) begin
          a_r  <= a_src_s[REM-1:CHUNK];
          bb_r <= bb_src_s[REM-1:CHUNK];
        end
      end
    end

`ifdef PIPE_ADD_OVF_EN
    if (g == STAGES - 1) begin : g_ovf
      logic ovf_r;

      // Top chunk holds the operand MSBs, so overflow is resolved here.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (!stall_s) begin
          ovf_r <= (a_src_s[CHUNK-1] == bb_src_s[CHUNK-1]) &&
                   (part_s[CHUNK-1] != a_src_s[CHUNK-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].c_r;
`ifdef PIPE_ADD_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_r;
`endif

endmodule
